// File: rtl/rtl_uart_pkg.sv
// Shared UART receive definitions: receiver states, frame constants and
// the default bit period derived from the system clock and baud rate.
package rtl_uart_pkg;

    localparam int unsigned CLK_HZ            = 12_000_000;
    localparam int unsigned BAUD              = 2_000_000;
    localparam int unsigned DEF_CLKS_PER_BIT  = CLK_HZ / BAUD;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separately tracked occupancy and a registered
// first-word-fall-through read port.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [$clog2(DEPTH):0]     fill_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             do_pop;
    logic             do_push;

    // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
    always_comb begin
        do_pop     = rd_en && (fill != '0);
        do_push    = wr_en && ((fill != FW'(DEPTH)) || do_pop);
        fill_nxt_c = fill + FW'(do_push) - FW'(do_pop);
        rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        head_nxt   = mem[rd_ptr_nxt];
        if (do_push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr   <= rd_ptr_nxt;
            fill     <= fill_nxt_c;
            rd_data  <= head_nxt;
            rd_valid <= (fill_nxt_c != '0);
            full     <= (fill_nxt_c == FW'(DEPTH));
            empty    <= (fill_nxt_c == '0);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with input synchroniser, byte FIFO, CTS flow control
// and sticky overflow reporting.
module uart_rx_fifo
    import rtl_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned HEADROOM     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        uart_rx,
    output logic                        uart_cts,
    output logic [UART_DATA_BITS-1:0]   m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(DEPTH):0]      fill
);

    localparam int unsigned FW        = $clog2(DEPTH) + 1;
    localparam int unsigned CW        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BW        = $clog2(UART_DATA_BITS);
    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int unsigned CTS_LEVEL = DEPTH - HEADROOM;

    logic [1:0]                sync_q;
    logic                      rxs;
    rx_state_t                 state;
    logic [CW-1:0]             cnt;
    logic [BW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      push;
    logic                      full;
    logic                      empty;
    logic [FW-1:0]             fill_nxt_c;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx};
        end
    end

    assign rxs = sync_q[1];

    // Receiver: each wait lasts cnt cycles and samples on the cycle cnt reads 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rxs) begin
                        state <= RX_START;
                        cnt   <= CW'(HALF_BIT);
                    end
                end
                RX_START: begin
                    if (cnt == CW'(1)) begin
                        if (rxs) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            cnt     <= CW'(CLKS_PER_BIT);
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(1)) begin
                        shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
                        cnt   <= CW'(CLKS_PER_BIT);
                        if (bit_idx == BW'(UART_DATA_BITS - 1)) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(1)) begin
                        if (rxs) begin
                            push  <= 1'b1;
                            state <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxs) begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (push),
        .wr_data    (shreg),
        .rd_en      (m_ready),
        .rd_data    (m_data),
        .rd_valid   (m_valid),
        .full       (full),
        .empty      (empty),
        .fill       (fill),
        .fill_nxt_c (fill_nxt_c)
    );

    // CTS tracks the occupancy the FIFO is about to hold; held off in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_cts <= 1'b1;
            overflow <= 1'b0;
        end else begin
            uart_cts <= (fill_nxt_c >= FW'(CTS_LEVEL));
            if (push && full && !(m_ready && !empty)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: serial frames are checked against a
// queue model of the byte stream, occupancy, flow control and error flags.
module tb_uart_rx_fifo;

    localparam int unsigned CPB      = 6;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned HEADROOM = 4;
    localparam int unsigned FW       = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          uart_rx;
    logic          uart_cts;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic          frame_err;
    logic          overflow;
    logic [FW-1:0] fill;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ferr = 0;
    int ferr_cnt = 0;
    int pop_cnt  = 0;
    int ready_mode = 0;
    bit exp_overflow = 1'b0;
    logic [7:0] model_q[$];

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .HEADROOM     (HEADROOM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .uart_cts  (uart_cts),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Consumer: sets m_ready for the coming edge, then scores any pop it causes.
    always @(negedge clk) begin
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (frame_err) ferr_cnt++;
        if (m_valid && m_ready) begin
            pop_cnt++;
            if (model_q.size() == 0) check("pop_with_nothing_expected", 32'(m_data), 32'h100);
            else check("pop_data", 32'(m_data), 32'(model_q.pop_front()));
        end
    end

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok, input bit track);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (track && stop_ok) begin
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else exp_overflow = 1'b1;
        end
        if (!stop_ok) exp_ferr++;
        drive_bit(stop_ok);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((model_q.size() != 0 || m_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(model_q.size()), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pops0;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        m_ready = 1'b0;

        // Reset values and CTS release
        repeat (3) @(negedge clk);
        check("rst_cts", 32'(uart_cts), 32'd1);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        #1 check("cts_before_edge", 32'(uart_cts), 32'd1);
        @(negedge clk);
        check("cts_after_release", 32'(uart_cts), 32'd0);
        check("valid_after_release", 32'(m_valid), 32'd0);
        check("fill_after_release", 32'(fill), 32'd0);

        // Back-to-back basic receive with latency of the first byte
        ready_mode = 1;
        repeat (2) @(negedge clk);
        pops0 = pop_cnt;
        fork
            begin
                send_byte(8'h00, 1'b1, 1'b1);
                send_byte(8'h01, 1'b1, 1'b1);
                send_byte(8'h02, 1'b1, 1'b1);
            end
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                end while (!m_valid && n < 200);
                check("rx_latency", 32'(n), 32'd61);
            end
        join
        drive_bit(1'b1);
        wait_drain("basic_drain");
        check("basic_pops", 32'(pop_cnt - pops0), 32'd3);
        check("basic_frame_err", 32'(ferr_cnt), 32'd0);

        // Flow control and overflow with the consumer stalled
        ready_mode = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h10 + i), 1'b1, 1'b1);
            repeat (3) @(negedge clk);
            check("fill_filling", 32'(fill), 32'(model_q.size()));
            check("cts_filling", 32'(uart_cts), 32'(model_q.size() >= DEPTH - HEADROOM));
        end
        check("overflow_before_full_push", 32'(overflow), 32'd0);
        send_byte(8'hAA, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("fill_full", 32'(fill), 32'(DEPTH));
        check("overflow_set", 32'(overflow), 32'(exp_overflow));
        check("cts_full", 32'(uart_cts), 32'd1);
        ready_mode = 1;
        wait_drain("flow_drain");
        @(negedge clk);
        check("fill_drained", 32'(fill), 32'd0);
        check("cts_drained", 32'(uart_cts), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Framing error then normal byte
        send_byte(8'h55, 1'b0, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_byte(8'h33, 1'b1, 1'b1);
        drive_bit(1'b1);
        wait_drain("ferr_drain");
        check("frame_err_count", 32'(ferr_cnt), 32'(exp_ferr));

        // Glitch rejection, then a frame right at the IDLE recovery bound
        pops0 = pop_cnt;
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB / 2 + 1) @(negedge clk);
        send_byte(8'h3C, 1'b1, 1'b1);
        drive_bit(1'b1);
        wait_drain("glitch_drain");
        check("glitch_pops", 32'(pop_cnt - pops0), 32'd1);
        check("glitch_frame_err", 32'(ferr_cnt), 32'(exp_ferr));

        // Reset during the data bits of a frame with two bytes buffered
        ready_mode = 0;
        send_byte(8'h21, 1'b1, 1'b1);
        send_byte(8'h22, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("fill_before_reset", 32'(fill), 32'd2);
        fork
            send_byte(8'hC3, 1'b1, 1'b0);
            begin
                repeat (30) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("reset_fill", 32'(fill), 32'd0);
                check("reset_cts", 32'(uart_cts), 32'd1);
                check("reset_valid", 32'(m_valid), 32'd0);
                check("reset_overflow", 32'(overflow), 32'd0);
                model_q.delete();
                exp_overflow = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        ready_mode = 1;
        pops0 = pop_cnt;
        send_byte(8'h5A, 1'b1, 1'b1);
        drive_bit(1'b1);
        wait_drain("reset_drain");
        check("reset_pops", 32'(pop_cnt - pops0), 32'd1);

        // Random bytes, gaps, framing errors and consumer stalls
        ready_mode = 2;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            bit bad;
            int gap;
            d   = 8'($urandom);
            bad = ($urandom_range(0, 9) == 0);
            send_byte(d, !bad, 1'b1);
            gap = bad ? 2 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) drive_bit(1'b1);
        end
        drive_bit(1'b1);
        ready_mode = 1;
        wait_drain("random_drain");
        @(negedge clk);
        check("random_fill", 32'(fill), 32'd0);
        check("random_frame_err", 32'(ferr_cnt), 32'(exp_ferr));
        check("random_overflow", 32'(overflow), 32'(exp_overflow));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive front end of the light controller. Deserialises the 8N1 host UART stream on `uart_rx` and buffers received bytes in a small FIFO. It drives the `uart_cts` flow-control line back to the host and presents bytes to the downstream frame parser over a valid/ready interface.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 6: clock cycles per UART bit (12 MHz clk, 2 Mbaud); minimum 4.
- `DEPTH`, default 16: FIFO entries; power of two.
- `HEADROOM`, default 4: free entries kept in reserve when CTS is deasserted; must be less than `DEPTH`.

Ports (clock and reset first):
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `uart_rx` in 1: serial input, idle high, asynchronous to `clk`.
- `uart_cts` out 1: clear-to-send, active-low. 0 means the host may send.
- `m_data` out 8: oldest buffered byte.
- `m_valid` out 1: `m_data` is valid (FIFO not empty).
- `m_ready` in 1: consumer accepts `m_data` on this cycle's rising edge when `m_valid` is high.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overflow` out 1: sticky flag; a byte was dropped because the FIFO was full. Cleared only by reset.
- `fill` out `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation

- `uart_rx` passes through a 2-FF synchroniser; its reset value is 1. All decoding uses the synchronised signal `rxs`.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on `rxs`==0, go to START and load the bit counter with `CLKS_PER_BIT/2` (integer division; 3 at the default).
- START: when the counter expires, resample `rxs`.
  - If `rxs`==1, it was a glitch: return to IDLE and push nothing.
  - Otherwise go to DATA with the bit index at 0.
- DATA: sample `rxs` every `CLKS_PER_BIT` cycles and shift it in LSB first. After 8 samples, go to STOP.
- STOP: sample `CLKS_PER_BIT` cycles after the last data bit.
  - If `rxs`==1, push the byte and go to IDLE.
  - If `rxs`==0, pulse `frame_err`, discard the byte and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rxs`==1, then go to IDLE. This prevents re-triggering inside a break.
- FIFO push: a single-cycle strobe, issued the cycle after a valid stop sample.
- FIFO pop: `m_valid && m_ready`.
- Simultaneous push and pop:
  - Non-empty FIFO: both take effect and `fill` is unchanged.
  - Full FIFO: the push is accepted because the pop frees a slot, so `overflow` does not set.
  - Empty FIFO: only the push takes effect, since `m_valid` is low.
- Push while full without a pop: the byte is dropped, `overflow` sets to 1, and `fill` stays at `DEPTH`.
- Flow control: `uart_cts` is registered and equals 1 whenever `fill >= DEPTH-HEADROOM`, otherwise 0. The host may complete the frame already in flight; `HEADROOM` absorbs it.
- Reset mid-frame: the FSM returns to IDLE and the FIFO empties. The partial byte is lost. A frame still in flight after reset release is handled by the glitch or framing rules.

## Timing

Output values during reset:
- `uart_cts`=1, so the host is held off.
- `m_valid`=0 and `m_data`=0x00.
- `frame_err`=0, `overflow`=0, `fill`=0.

After `rst_n` rises, `uart_cts` goes to 0 on the first `clk` edge.

Receive latency:
- The stop bit is sampled `2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles after the falling edge reaches `uart_rx`. That is 59 cycles at the default.
- The push strobe follows 1 cycle later.
- `m_valid` and `m_data` update on the cycle after the push. The FIFO read data is registered, first-word fall-through.

Other timing:
- `fill` and `uart_cts` change one cycle after the push or pop that causes the change.
- Back-to-back frames (stop bit followed immediately by a start bit) are received without loss. IDLE detects the next start within 1 cycle.
- Counters wrap modulo `DEPTH` on the pointers, with `fill` tracked separately, so full and empty are unambiguous.

## Structure

- Shared package `rtl_uart_pkg` holds:
  - the receiver state enum `rx_state_t`;
  - the constant `UART_DATA_BITS`=8;
  - the default `CLKS_PER_BIT` derived from `CLK_HZ`=12_000_000 and `BAUD`=2_000_000.
- Sub-module `sync_fifo` (parameters: width, depth): handles storage, pointers, `fill` and the full/empty flags.
- The `uart_rx_fifo` top contains the synchroniser, the receiver FSM, the CTS logic and the overflow logic.

## Test plan

1. **Reset release:** release `rst_n` with `uart_rx` idle high. Expect `uart_cts` to fall to 0 one cycle later, with `m_valid`=0 and `fill`=0.
2. **Basic receive:** send 0x00, 0x01, 0x02 back-to-back at 500 ns per bit (12 MHz clk), with `m_ready`=1. Expect `m_data` 0x00, 0x01, 0x02 in order, exactly three pops, and `frame_err` never pulsing.
3. **Flow control and overflow:** hold `m_ready`=0 and send bytes 0x10 through 0x1F.
   - `uart_cts` must rise after the 12th byte, when `fill`=12.
   - Keep sending through a 17th byte (0xAA) while ignoring CTS. Expect `fill`=16, `overflow`=1, and 0xAA absent from the drained data.
4. **Framing error:** send 0x55 with the stop bit forced low for one bit time, then send 0x33 normally. Expect one `frame_err` pulse, no 0x55 in the FIFO, and 0x33 received.
5. **Glitch rejection:** drive a 2-cycle low pulse on `uart_rx`. Expect no push, and the FSM back in IDLE within `CLKS_PER_BIT/2+3` cycles.
6. **Reset mid-frame:** assert `rst_n`=0 during the DATA bits of 0xC3, with 2 bytes already buffered. Expect `fill`=0 and `uart_cts`=1 immediately. After release, a new 0x5A is received correctly.
